// File: rtl/pcs_tx_byte_sequencer.sv
// TX PCS byte sequencer: buffers 1/2/4-byte PIPE words with per-byte K flags and
// serialises them LSB-first, one byte per symbol clock, toward the 8b/10b encoder.
module pcs_tx_byte_sequencer #(
    parameter int DEPTH = 2
) (
    input  logic        Bit_Rate_10,
    input  logic        Rst,
    input  logic [31:0] TXData,
    input  logic [3:0]  TXDataK,
    input  logic        TXDataValid,
    input  logic [1:0]  Width,
    output logic        TXReady,
    output logic [7:0]  data,
    output logic        data_k,
    output logic        enable
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   data_mem [DEPTH];
    logic [3:0]    k_mem    [DEPTH];
    logic [1:0]    last_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [1:0]    byte_cnt;
    logic [1:0]    push_last;
    logic          push;
    logic          pop;
    logic          empty;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign TXReady = Rst && (count < CW'(DEPTH));
    assign push    = TXDataValid && TXReady;
    assign pop     = !empty && (byte_cnt == last_mem[rd_ptr]);

    // Each entry keeps the index of its final byte rather than the byte count.
    always_comb begin
        push_last = 2'd3;
        case (Width)
            2'b00:   push_last = 2'd0;
            2'b01:   push_last = 2'd1;
            default: push_last = 2'd3;
        endcase
    end

    always_ff @(posedge Bit_Rate_10) begin
        if (push) begin
            data_mem[wr_ptr] <= TXData;
            k_mem[wr_ptr]    <= TXDataK;
            last_mem[wr_ptr] <= push_last;
        end
    end

    always_ff @(posedge Bit_Rate_10 or negedge Rst) begin
        if (!Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Output stage only sees entries committed on earlier edges, giving one cycle of latency.
    always_ff @(posedge Bit_Rate_10 or negedge Rst) begin
        if (!Rst) begin
            data     <= 8'h00;
            data_k   <= 1'b0;
            enable   <= 1'b0;
            byte_cnt <= 2'd0;
        end else if (!empty) begin
            data     <= data_mem[rd_ptr][{byte_cnt, 3'b000} +: 8];
            data_k   <= k_mem[rd_ptr][byte_cnt];
            enable   <= 1'b1;
            byte_cnt <= pop ? 2'd0 : byte_cnt + 2'd1;
        end else begin
            enable   <= 1'b0;
            byte_cnt <= 2'd0;
        end
    end

endmodule

// File: tb/tb_pcs_tx_byte_sequencer.sv
// Bench for pcs_tx_byte_sequencer: directed scenarios plus random traffic, scored
// against a word-queue model of the byte stream.
module tb_pcs_tx_byte_sequencer;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] tx_data;
    logic [3:0]  tx_k;
    logic        tx_valid;
    logic [1:0]  width;
    logic        tx_ready;
    logic [7:0]  data;
    logic        data_k;
    logic        enable;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        int          n;
    } word_t;

    word_t      wq[$];
    int         head_idx;
    logic [7:0] exp_data;
    logic       exp_k;
    logic       exp_en;
    int         total;
    int         passed;

    pcs_tx_byte_sequencer #(.DEPTH(DEPTH)) dut (
        .Bit_Rate_10 (clk),
        .Rst         (rst_n),
        .TXData      (tx_data),
        .TXDataK     (tx_k),
        .TXDataValid (tx_valid),
        .Width       (width),
        .TXReady     (tx_ready),
        .data        (data),
        .data_k      (data_k),
        .enable      (enable)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One clock edge of the reference: emit the next byte of the oldest word, then enqueue.
    task automatic modelEdge(input logic accept, input logic [31:0] d, input logic [3:0] k,
                             input logic [1:0] w);
        word_t h;
        word_t nw;
        if (wq.size() > 0) begin
            h        = wq[0];
            exp_data = 8'(h.d >> (8 * head_idx));
            exp_k    = h.k[head_idx];
            exp_en   = 1'b1;
            head_idx++;
            if (head_idx == h.n) begin
                void'(wq.pop_front());
                head_idx = 0;
            end
        end else begin
            exp_en = 1'b0;
        end
        if (accept) begin
            nw.d = d;
            nw.k = k;
            nw.n = (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
            wq.push_back(nw);
        end
    endtask

    task automatic modelReset();
        wq.delete();
        head_idx = 0;
        exp_data = 8'h00;
        exp_k    = 1'b0;
        exp_en   = 1'b0;
    endtask

    // Called at a falling edge; drives one cycle and checks the registered result.
    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic [3:0] k,
                                 input logic [1:0] w, output logic accepted);
        logic model_ready;
        tx_valid = v;
        tx_data  = d;
        tx_k     = k;
        width    = w;
        model_ready = (wq.size() < DEPTH);
        #1;
        checkOutput("tx_ready", 32'(tx_ready), 32'(model_ready));
        accepted = v && model_ready;
        @(posedge clk);
        modelEdge(accepted, d, k, w);
        @(negedge clk);
        checkOutput("enable", 32'(enable), 32'(exp_en));
        checkOutput("data", 32'(data), 32'(exp_data));
        checkOutput("data_k", 32'(data_k), 32'(exp_k));
    endtask

    task automatic pushWord(input logic [31:0] d, input logic [3:0] k, input logic [1:0] w);
        logic acc;
        int   tries;
        tries = 0;
        do begin
            applyStimulus(1'b1, d, k, w, acc);
            tries++;
        end while (!acc && tries < 20);
        if (!acc) checkOutput("push_timeout", 32'(acc), 32'd1);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 4'h0, 2'b10, acc);
    endtask

    task automatic midReset();
        #2 rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("rst_enable", 32'(enable), 32'd0);
        checkOutput("rst_ready", 32'(tx_ready), 32'd0);
        checkOutput("rst_data", 32'(data), 32'h00);
        tx_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic acc;
        total    = 0;
        passed   = 0;
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        tx_k     = '0;
        width    = 2'b00;
        modelReset();
        @(negedge clk);
        checkOutput("reset_enable", 32'(enable), 32'd0);
        checkOutput("reset_ready", 32'(tx_ready), 32'd0);
        checkOutput("reset_data", 32'(data), 32'h00);
        checkOutput("reset_k", 32'(data_k), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] scenario: single 4-byte word");
        pushWord(32'h4A3C1CBC, 4'b0001, 2'b10);
        idle(6);

        $display("[TB] scenario: three back-to-back 4-byte words");
        pushWord(32'hA3A2A1A0, 4'b0000, 2'b10);
        pushWord(32'hB3B2B1B0, 4'b1000, 2'b10);
        pushWord(32'hC3C2C1C0, 4'b0100, 2'b10);
        idle(14);

        $display("[TB] scenario: one-byte words every cycle");
        for (int i = 1; i <= 8; i++) pushWord(32'(i), 4'b0000, 2'b00);
        idle(3);

        $display("[TB] scenario: mixed widths");
        pushWord(32'h0000BCF7, 4'b0011, 2'b01);
        pushWord(32'h11223344, 4'b0000, 2'b10);
        idle(8);

        $display("[TB] scenario: reset mid-word");
        pushWord(32'h87654321, 4'b0000, 2'b10);
        idle(2);
        midReset();
        idle(6);

        $display("[TB] scenario: width 11 as four bytes");
        pushWord(32'hDEADBEEF, 4'b0000, 2'b11);
        idle(6);

        $display("[TB] scenario: random traffic");
        for (int i = 0; i < 300; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom, 4'($urandom),
                          2'($urandom), acc);
        end
        idle(12);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
